pe_ctx_seq: RTL and testbench
=============================

Name: pe_ctx_seq

Overview:
- Parametrised multi-context CGRA processing element; next generation of the single-instruction PE.
- Holds CTX_DEPTH instructions in a local context memory, loaded over a config port.
- A sequencer steps through ctx_len contexts for iter_cnt iterations.
- Routes N/S/W/E/LSU inputs, an NREG-entry register file and the FU result to the five outputs through a per-context crossbar.

Parameters:
- DW, 32, datapath width.
- NREG, 4, register file entries.
- CTX_DEPTH, 8, context memory depth (power of two).
- ITER_W, 16, iteration counter width.
- Derived: SW = clog2(7+NREG); AW = clog2(CTX_DEPTH); INST_W = 4 + 8*SW + NREG (40 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  AW  context write address.
- cfg_data  in  INST_W  context word.
- start  in  1  begin execution, one-cycle pulse.
- ctx_len  in  AW+1  number of contexts per iteration.
- iter_cnt  in  ITER_W  number of iterations.
- din_N / din_S / din_W / din_E / din_LSU  in  DW each  neighbour and LSU inputs.
- dout_N / dout_S / dout_W / dout_E / dout_LSU  out  DW each  registered outputs.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at completion.
- pc  out  AW  current context index.

Behaviour:
- Context word layout, MSB to LSB: opcode[4], lsu_sel, opA_sel, opB_sel, N_sel, S_sel, W_sel, E_sel, wr_src (each SW bits), wr_en[NREG].
- Source codes: 0=din_N, 1=din_S, 2=din_W, 3=din_E, 4=din_LSU, 5=FU result (same cycle, combinational), 6=zero, 7..6+NREG=R0..R(NREG-1). Any other code selects 0.
- FU opcodes:
  - 0 ADD, 1 SUB (A-B), 2 MUL (low DW bits), 3 AND, 4 OR, 5 XOR.
  - 6 SHL, 7 SHR logical; shift amount = B[clog2(DW)-1:0].
  - 8 SLT signed (result 1/0), 9 PASS A.
  - 10-15 give 0.
  - All arithmetic wraps modulo 2^DW.
- Sequencer states: IDLE, RUN, DONE.
  - IDLE: a start pulse with ctx_len!=0 and iter_cnt!=0 latches both values, sets pc=0 and moves to RUN.
  - IDLE: a start pulse with ctx_len==0 or iter_cnt==0 moves to DONE with no execution.
  - RUN: each cycle executes context[pc].
    - pc increments.
    - When pc==ctx_len-1, pc wraps to 0 and the iteration counter decrements.
    - On the last context of the last iteration, moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - ctx_len > CTX_DEPTH is clamped to CTX_DEPTH at latch time.
- Timing:
  - Outputs and register writes update at the clock edge ending the execute cycle, i.e. 1-cycle latency.
  - The register file is read before it is written; a same-cycle write is not forwarded.
  - Every Rk with wr_en[k]=1 loads the value selected by wr_src.
- Outside RUN: dout_*, registers and pc hold their values; busy=0.
- start during RUN or DONE is ignored.
- Config writes:
  - cfg_we in IDLE writes the context word.
  - cfg_we in RUN or DONE is dropped and the memory is unchanged.
  - A write and a start in the same IDLE cycle: the write completes and execution starts next cycle, using the new word.
- Reset, including mid-RUN: state=IDLE; pc, counters, registers and all dout_* = 0; busy=0, done=0. Context memory is not reset.

Optional Feature:
- Macro: PE_STALL_EN.
- When defined:
  - Adds input port stall (1 bit).
  - stall=1 in RUN freezes pc, the iteration counter, registers and dout_*; no context executes and no write occurs.
  - The stalled context executes in the first cycle with stall=0.
  - stall is ignored outside RUN.
  - done is delayed by the number of stalled RUN cycles.
- When undefined: no stall port; RUN advances every cycle.

Test Plan:
- Single context and single iteration, with din_N=5, din_E=8, din_LSU=9:
  - Context: ADD, opA=N, opB=E, S_sel=FU, wr_src=LSU, wr_en=R0, N_sel=R0.
  - Cycle 1: dout_S=13, R0=9, dout_N=0.
  - done pulses one cycle after RUN ends.
- Two contexts, iter_cnt=3:
  - ctx0: R1<=R1+din_W (din_W=7). ctx1: dout_E=R1.
  - dout_E takes 7, 14, 21 on successive ctx1 executions.
  - Exactly 6 RUN cycles, busy=1 throughout, pc sequence 0,1,0,1,0,1.
- FU sweep:
  - A=0xFFFFFFFF, B=1: ADD=0, SUB=0xFFFFFFFE, SLT=1, SHR=0x7FFFFFFF.
  - A=3, B=5: MUL=15.
  - opcode 12 gives 0.
- Edge cases:
  - start with iter_cnt=0 gives done on the next cycle, outputs unchanged.
  - start and cfg_we during RUN are both ignored; the memory readback is unchanged on the next run.
  - Reset asserted mid-RUN: all outputs 0 immediately; a subsequent start runs from pc=0.
- PE_STALL_EN with a 2-context, 1-iteration program:
  - stall held high for 3 cycles after the first context: pc stays 1 and dout holds.
  - done arrives 3 cycles later than in the unstalled run.

Source files
------------

// File: rtl/pe_ctx_seq.sv
// rtl/pe_ctx_seq.sv - multi-context CGRA PE with context sequencer and output crossbar
// Optional macro PE_STALL_EN adds a stall input that freezes execution in RUN.
module pe_ctx_seq #(
    parameter  int DW        = 32,
    parameter  int NREG      = 4,
    parameter  int CTX_DEPTH = 8,
    parameter  int ITER_W    = 16,
    localparam int SW        = $clog2(7 + NREG),
    localparam int AW        = $clog2(CTX_DEPTH),
    localparam int INST_W    = 4 + 8 * SW + NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [INST_W-1:0] cfg_data,
    input  logic              start,
`ifdef PE_STALL_EN
    input  logic              stall,
`endif
    input  logic [AW:0]       ctx_len,
    input  logic [ITER_W-1:0] iter_cnt,
    input  logic [DW-1:0]     din_N,
    input  logic [DW-1:0]     din_S,
    input  logic [DW-1:0]     din_W,
    input  logic [DW-1:0]     din_E,
    input  logic [DW-1:0]     din_LSU,
    output logic [DW-1:0]     dout_N,
    output logic [DW-1:0]     dout_S,
    output logic [DW-1:0]     dout_W,
    output logic [DW-1:0]     dout_E,
    output logic [DW-1:0]     dout_LSU,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     pc
);
    localparam int NSRC    = 1 << SW;
    localparam int SHW     = $clog2(DW);
    localparam int OFF_WR  = NREG;
    localparam int OFF_E   = NREG + SW;
    localparam int OFF_W   = NREG + 2 * SW;
    localparam int OFF_S   = NREG + 3 * SW;
    localparam int OFF_N   = NREG + 4 * SW;
    localparam int OFF_B   = NREG + 5 * SW;
    localparam int OFF_A   = NREG + 6 * SW;
    localparam int OFF_LSU = NREG + 7 * SW;
    localparam int OFF_OP  = NREG + 8 * SW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW:0]       len_q, len_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              exec;
    logic              stall_i;
    logic              last_ctx;

    logic [INST_W-1:0] mem [CTX_DEPTH];
    logic [INST_W-1:0] inst;
    logic [DW-1:0]     regs [NREG];
    logic [DW-1:0]     srcs [NSRC];

    logic [3:0]        opcode;
    logic [SW-1:0]     lsu_sel, opa_sel, opb_sel, n_sel, s_sel, w_sel, e_sel, wr_src;
    logic [NREG-1:0]   wr_en;
    logic [DW-1:0]     a_val, b_val, fu_res;
    logic [DW-1:0]     n_val, s_val, w_val, e_val, lsu_val, wr_val;

`ifdef PE_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_IDLE) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    assign inst    = mem[pc_q];
    assign opcode  = inst[OFF_OP  +: 4];
    assign lsu_sel = inst[OFF_LSU +: SW];
    assign opa_sel = inst[OFF_A   +: SW];
    assign opb_sel = inst[OFF_B   +: SW];
    assign n_sel   = inst[OFF_N   +: SW];
    assign s_sel   = inst[OFF_S   +: SW];
    assign w_sel   = inst[OFF_W   +: SW];
    assign e_sel   = inst[OFF_E   +: SW];
    assign wr_src  = inst[OFF_WR  +: SW];
    assign wr_en   = inst[NREG-1:0];

    // Slot 5 stays zero here so operands can never loop through the FU result.
    always_comb begin
        for (int i = 0; i < NSRC; i++) srcs[i] = '0;
        srcs[0] = din_N;
        srcs[1] = din_S;
        srcs[2] = din_W;
        srcs[3] = din_E;
        srcs[4] = din_LSU;
        for (int k = 0; k < NREG; k++) srcs[7 + k] = regs[k];
    end

    assign a_val = srcs[opa_sel];
    assign b_val = srcs[opb_sel];

    always_comb begin
        fu_res = '0;
        case (opcode)
            4'd0:    fu_res = a_val + b_val;
            4'd1:    fu_res = a_val - b_val;
            4'd2:    fu_res = a_val * b_val;
            4'd3:    fu_res = a_val & b_val;
            4'd4:    fu_res = a_val | b_val;
            4'd5:    fu_res = a_val ^ b_val;
            4'd6:    fu_res = a_val << b_val[SHW-1:0];
            4'd7:    fu_res = a_val >> b_val[SHW-1:0];
            4'd8:    fu_res = {{(DW-1){1'b0}}, ($signed(a_val) < $signed(b_val))};
            4'd9:    fu_res = a_val;
            default: fu_res = '0;
        endcase
    end

    assign n_val   = (n_sel   == SW'(5)) ? fu_res : srcs[n_sel];
    assign s_val   = (s_sel   == SW'(5)) ? fu_res : srcs[s_sel];
    assign w_val   = (w_sel   == SW'(5)) ? fu_res : srcs[w_sel];
    assign e_val   = (e_sel   == SW'(5)) ? fu_res : srcs[e_sel];
    assign lsu_val = (lsu_sel == SW'(5)) ? fu_res : srcs[lsu_sel];
    assign wr_val  = (wr_src  == SW'(5)) ? fu_res : srcs[wr_src];

    assign last_ctx = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        iter_d  = iter_q;
        exec    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ctx_len == '0 || iter_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        pc_d    = '0;
                        iter_d  = iter_cnt;
                        len_d   = (ctx_len > (AW+1)'(CTX_DEPTH)) ? (AW+1)'(CTX_DEPTH) : ctx_len;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!stall_i) begin
                    exec = 1'b1;
                    if (last_ctx) begin
                        pc_d   = '0;
                        iter_d = iter_q - ITER_W'(1);
                        if (iter_q == ITER_W'(1)) state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            iter_q   <= '0;
            dout_N   <= '0;
            dout_S   <= '0;
            dout_W   <= '0;
            dout_E   <= '0;
            dout_LSU <= '0;
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            iter_q  <= iter_d;
            if (exec) begin
                dout_N   <= n_val;
                dout_S   <= s_val;
                dout_W   <= w_val;
                dout_E   <= e_val;
                dout_LSU <= lsu_val;
                for (int k = 0; k < NREG; k++) begin
                    if (wr_en[k]) regs[k] <= wr_val;
                end
            end
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// tb/tb_pe_ctx_seq.sv - scoreboard bench for pe_ctx_seq against a behavioural context model
module tb_pe_ctx_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [39:0] cfg_data;
    logic        start;
    logic        stall;
    logic [3:0]  ctx_len;
    logic [15:0] iter_cnt;
    logic [31:0] din_N, din_S, din_W, din_E, din_LSU;
    logic [31:0] dout_N, dout_S, dout_W, dout_E, dout_LSU;
    logic        busy, done;
    logic [2:0]  pc;

    always #5 clk = ~clk;

    pe_ctx_seq dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start),
`ifdef PE_STALL_EN
        .stall(stall),
`endif
        .ctx_len(ctx_len), .iter_cnt(iter_cnt),
        .din_N(din_N), .din_S(din_S), .din_W(din_W), .din_E(din_E), .din_LSU(din_LSU),
        .dout_N(dout_N), .dout_S(dout_S), .dout_W(dout_W), .dout_E(dout_E), .dout_LSU(dout_LSU),
        .busy(busy), .done(done), .pc(pc)
    );

    int checks = 0;
    int failures = 0;

    int           pc_q[$];
    logic [159:0] out_q[$];

    logic [39:0] m_mem [8];
    logic [31:0] m_reg [4];
    logic [31:0] m_dout [5];
    logic [31:0] m_din [5];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] dut_outs();
        return {dout_N, dout_S, dout_W, dout_E, dout_LSU};
    endfunction

    function automatic logic [159:0] m_pack();
        return {m_dout[0], m_dout[1], m_dout[2], m_dout[3], m_dout[4]};
    endfunction

    function automatic logic [39:0] mk(input int op, input int lsu, input int a, input int b,
                                       input int n, input int s, input int w, input int e,
                                       input int wr, input int en);
        return {4'(op), 4'(lsu), 4'(a), 4'(b), 4'(n), 4'(s), 4'(w), 4'(e), 4'(wr), 4'(en)};
    endfunction

    function automatic int rsel_op();
        int v;
        v = int'($urandom_range(0, 15));
        if (v == 5) v = 6;
        return v;
    endfunction

    function automatic logic [39:0] rand_word();
        return mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), rsel_op(), rsel_op(),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endfunction

    // Source code -> value, as the instruction set defines it.
    function automatic logic [31:0] m_src(input int sel, input logic [31:0] fu);
        if (sel < 5)   return m_din[sel];
        if (sel == 5)  return fu;
        if (sel == 6)  return 32'd0;
        if (sel <= 10) return m_reg[sel-7];
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_fu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int          sh;
        sh = int'(b % 32);
        prod = 64'(a) * 64'(b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return prod[31:0];
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return a << sh;
            7: return a >> sh;
            8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9: return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_exec(input logic [39:0] w);
        logic [31:0] fu, nv, sv, wv, ev, lv, rv;
        int en;
        fu = m_fu(int'(w[39:36]), m_src(int'(w[31:28]), 32'd0), m_src(int'(w[27:24]), 32'd0));
        lv = m_src(int'(w[35:32]), fu);
        nv = m_src(int'(w[23:20]), fu);
        sv = m_src(int'(w[19:16]), fu);
        wv = m_src(int'(w[15:12]), fu);
        ev = m_src(int'(w[11:8]), fu);
        rv = m_src(int'(w[7:4]), fu);
        en = int'(w[3:0]);
        for (int k = 0; k < 4; k++) if (en[k]) m_reg[k] = rv;
        m_dout[0] = nv; m_dout[1] = sv; m_dout[2] = wv; m_dout[3] = ev; m_dout[4] = lv;
    endtask

    task automatic set_din(input logic [31:0] n, input logic [31:0] s, input logic [31:0] w,
                           input logic [31:0] e, input logic [31:0] l);
        din_N = n; din_S = s; din_W = w; din_E = e; din_LSU = l;
        m_din[0] = n; m_din[1] = s; m_din[2] = w; m_din[3] = e; m_din[4] = l;
    endtask

    task automatic cfg_write(input int a, input logic [39:0] w);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = w;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_mem[a] = w;
    endtask

    task automatic rand_program();
        for (int a = 0; a < 8; a++) cfg_write(a, rand_word());
        set_din($urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic launch(input int len, input int iters, input bit wr, input int waddr,
                          input logic [39:0] wword, output int n);
        int el;
        if (wr) m_mem[waddr] = wword;
        el = (len > 8) ? 8 : len;
        n = (len == 0 || iters == 0) ? 0 : el * iters;
        if (n > 0) begin
            for (int it = 0; it < iters; it++) begin
                for (int p = 0; p < el; p++) begin
                    pc_q.push_back(p);
                    m_exec(m_mem[p]);
                    out_q.push_back(m_pack());
                end
            end
        end
        ctx_len = 4'(len); iter_cnt = 16'(iters); start = 1'b1;
        if (wr) begin cfg_we = 1'b1; cfg_addr = 3'(waddr); cfg_data = wword; end
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic finish_run(input int n, input int stall_at, input int stall_len, input bit junk);
        int cycles, budget, expc;
        int hold_pc;
        logic [159:0] hold_out;
        cycles = 0;
        budget = n + stall_len + 10;
        expc = n + ((n > 0) ? stall_len : 0);
        hold_pc = 0;
        hold_out = '0;
        while (!done && cycles < budget) begin
            if (stall) begin
                chk("stall_pc_hold", pc, hold_pc);
                chk("stall_dout_hold", dut_outs(), hold_out);
            end
            if (stall_len > 0 && cycles == stall_at + stall_len) stall = 1'b0;
            if (stall_len > 0 && cycles == stall_at) begin
                stall = 1'b1; hold_pc = int'(pc); hold_out = dut_outs();
            end
            if (junk && cycles == 1) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 40'({$urandom, $urandom});
            end
            if (junk && cycles == 2) begin start = 1'b0; cfg_we = 1'b0; end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0; cfg_we = 1'b0; stall = 1'b0;
        chk("done_pulse", done, 1);
        chk("run_cycles", cycles, expc);
        chk("busy_in_done", busy, 0);
        ctx_len = 4'd2; iter_cnt = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("start_in_done_ignored", busy, 0);
        chk("pc_queue_drained", pc_q.size(), 0);
        chk("out_queue_drained", out_q.size(), 0);
        chk("final_outs", dut_outs(), m_pack());
    endtask

    bit pending = 0;
    always @(negedge clk) begin
        if (rst) begin
            pending = 0;
        end else begin
            if (pending) begin
                if (out_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=0x%0h expected=none", dut_outs());
                end else begin
                    chk("dout_scoreboard", dut_outs(), out_q.pop_front());
                end
            end
            pending = busy && !stall;
            if (busy && !stall) begin
                if (pc_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_exec actual_pc=%0d expected=idle", pc);
                end else begin
                    chk("pc_scoreboard", pc, pc_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    int n;
    logic [31:0] sw_a [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3};
    logic [31:0] sw_b [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5};
    int          sw_op[6] = '{0, 1, 8, 7, 2, 12};
    logic [31:0] sw_x [6] = '{32'd0, 32'hFFFFFFFE, 32'd1, 32'h7FFFFFFF, 32'd15, 32'd0};

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; stall = 1'b0;
        ctx_len = '0; iter_cnt = '0;
        set_din(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) m_reg[k] = '0;
        for (int k = 0; k < 5; k++) m_dout[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_douts", dut_outs(), '0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pc", pc, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // single context: ADD N+E -> S, R0 <= LSU, N <= R0
        set_din(5, 0, 0, 8, 9);
        cfg_write(0, mk(0, 6, 0, 3, 7, 5, 6, 6, 4, 1));
        launch(1, 1, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);
        chk("t1_dout_S", dout_S, 13);
        chk("t1_dout_N", dout_N, 0);

        // accumulator: R1 += din_W, then dout_E = R1, three iterations
        set_din(0, 0, 7, 0, 0);
        cfg_write(0, mk(0, 6, 8, 2, 6, 6, 6, 6, 5, 2));
        cfg_write(1, mk(9, 6, 6, 6, 6, 6, 6, 8, 6, 0));
        launch(2, 3, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);
        chk("t2_dout_E", dout_E, 21);

        // FU sweep, each word written in the same cycle as start
        for (int i = 0; i < 6; i++) begin
            set_din(sw_a[i], sw_b[i], 0, 0, 0);
            launch(1, 1, 1, 0, mk(sw_op[i], 5, 0, 1, 6, 6, 6, 6, 6, 0), n);
            finish_run(n, 0, 0, 0);
            chk("fu_sweep", dout_LSU, sw_x[i]);
        end

        // zero-length and zero-iteration starts
        launch(3, 0, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);
        launch(0, 2, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);

        // start and cfg_we during RUN are dropped; rerun reuses the same memory
        rand_program();
        launch(4, 2, 0, 0, '0, n);
        finish_run(n, 0, 0, 1);
        launch(4, 1, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);

        // ctx_len above depth clamps to 8
        rand_program();
        launch(12, 2, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);

        for (int r = 0; r < 15; r++) begin
            if ($urandom_range(0, 1) == 1) rand_program();
            else set_din($urandom, $urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 2) == 0)
                launch(int'($urandom_range(1, 15)), int'($urandom_range(1, 3)), 1,
                       int'($urandom_range(0, 7)), rand_word(), n);
            else
                launch(int'($urandom_range(1, 15)), int'($urandom_range(1, 3)), 0, 0, '0, n);
            finish_run(n, 0, 0, 0);
        end

        // reset in the middle of a long run
        rand_program();
        launch(8, 50, 0, 0, '0, n);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        pc_q.delete(); out_q.delete();
        for (int k = 0; k < 4; k++) m_reg[k] = '0;
        for (int k = 0; k < 5; k++) m_dout[k] = '0;
        chk("midrun_reset_douts", dut_outs(), '0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_pc", pc, 0);
        chk("midrun_reset_done", done, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        launch(3, 2, 0, 0, '0, n);
        finish_run(n, 0, 0, 0);

`ifdef PE_STALL_EN
        // stall held for three cycles after the first context
        rand_program();
        launch(2, 1, 0, 0, '0, n);
        finish_run(n, 1, 3, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
